// File: rtl/pll_lock_sequencer_pkg.sv
// Shared definitions for the PLL lock sequencer: state codes, default timing
// parameters and a saturating counter helper.
package pll_lock_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    localparam int DEF_PLL_RST_CYCLES     = 16;
    localparam int DEF_LOCK_STABLE_CYCLES = 1024;
    localparam int DEF_LOCK_TIMEOUT       = 65535;
    localparam int DEF_MAX_RETRIES        = 3;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input; clears to 0 on reset.
module pll_lock_sequencer_sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// Sequences the LCD pixel-clock PLL: pulses its reset, waits for a stable lock,
// then releases the downstream domain. Retries on timeout and parks in FAULT.
module pll_lock_sequencer
    import pll_lock_sequencer_pkg::*;
#(
    parameter int PLL_RST_CYCLES     = DEF_PLL_RST_CYCLES,
    parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int LOCK_TIMEOUT       = DEF_LOCK_TIMEOUT,
    parameter int MAX_RETRIES        = DEF_MAX_RETRIES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock,
    input  logic       restart_req,
    output logic       pll_reset,
    output logic       lcd_rst,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_cnt,
    output logic [7:0] loss_cnt,
    output logic [2:0] state
);

    localparam int PHASE_W = $clog2(PLL_RST_CYCLES + 1);
    localparam int TMO_W   = $clog2(LOCK_TIMEOUT + 1);
    localparam int STAB_W  = $clog2(LOCK_STABLE_CYCLES + 1);

    localparam logic [PHASE_W-1:0] PHASE_LAST  = PHASE_W'(PLL_RST_CYCLES - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST    = TMO_W'(LOCK_TIMEOUT - 1);
    localparam logic [STAB_W-1:0]  STAB_LAST   = STAB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [3:0]         RETRY_LIMIT = 4'(MAX_RETRIES);

    state_t              st;
    logic                lock_s;
    logic [PHASE_W-1:0]  phase;
    logic [TMO_W-1:0]    tmo;
    logic [STAB_W-1:0]   stab;
    logic                timeout;
    logic [3:0]          retry_next;

    pll_lock_sequencer_sync_2ff u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_lock),
        .q   (lock_s)
    );

    assign timeout    = (tmo == TMO_LAST);
    assign retry_next = retry_cnt + 4'd1;

    // The timeout timer spans WAIT_LOCK and STABLE so a chattering lock cannot
    // keep an attempt alive forever; timeout wins over every other exit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= ST_PLL_RST;
            phase     <= '0;
            tmo       <= '0;
            stab      <= '0;
            retry_cnt <= 4'd0;
            loss_cnt  <= 8'd0;
        end else begin
            case (st)
                ST_PLL_RST: begin
                    tmo  <= '0;
                    stab <= '0;
                    if (phase == PHASE_LAST) begin
                        phase <= '0;
                        st    <= ST_WAIT_LOCK;
                    end else begin
                        phase <= phase + PHASE_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    tmo  <= tmo + TMO_W'(1);
                    stab <= '0;
                    if (timeout) begin
                        retry_cnt <= retry_next;
                        st        <= (retry_next == RETRY_LIMIT) ? ST_FAULT : ST_PLL_RST;
                    end else if (lock_s) begin
                        st <= ST_STABLE;
                    end
                end
                ST_STABLE: begin
                    tmo <= tmo + TMO_W'(1);
                    if (timeout) begin
                        retry_cnt <= retry_next;
                        st        <= (retry_next == RETRY_LIMIT) ? ST_FAULT : ST_PLL_RST;
                    end else if (!lock_s) begin
                        stab <= '0;
                        st   <= ST_WAIT_LOCK;
                    end else if (stab == STAB_LAST) begin
                        stab      <= '0;
                        retry_cnt <= 4'd0;
                        st        <= ST_RUN;
                    end else begin
                        stab <= stab + STAB_W'(1);
                    end
                end
                ST_RUN: begin
                    // A lock loss coinciding with a restart is still recorded as a loss.
                    if (!lock_s) begin
                        loss_cnt <= sat_inc8(loss_cnt);
                        st       <= ST_PLL_RST;
                    end else if (restart_req) begin
                        st <= ST_PLL_RST;
                    end
                end
                ST_FAULT: begin
                    if (restart_req) begin
                        retry_cnt <= 4'd0;
                        st        <= ST_PLL_RST;
                    end
                end
                default: st <= ST_PLL_RST;
            endcase
        end
    end

    assign state     = st;
    assign pll_reset = (st == ST_PLL_RST) || (st == ST_FAULT);
    assign lcd_rst   = (st != ST_RUN);
    assign ready     = (st == ST_RUN);
    assign fault     = (st == ST_FAULT);

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with short timing parameters:
// PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT=32, MAX_RETRIES=2.
module tb_pll_lock_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_lock;
    logic       restart_req;
    logic       pll_reset;
    logic       lcd_rst;
    logic       ready;
    logic       fault;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;
    logic [2:0] state;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    pll_lock_sequencer #(
        .PLL_RST_CYCLES     (4),
        .LOCK_STABLE_CYCLES (8),
        .LOCK_TIMEOUT       (32),
        .MAX_RETRIES        (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pll_lock    (pll_lock),
        .restart_req (restart_req),
        .pll_reset   (pll_reset),
        .lcd_rst     (lcd_rst),
        .ready       (ready),
        .fault       (fault),
        .retry_cnt   (retry_cnt),
        .loss_cnt    (loss_cnt),
        .state       (state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"},     32'(state),     32'd0);
        chk({tag, "_pll_reset"}, 32'(pll_reset), 32'd1);
        chk({tag, "_lcd_rst"},   32'(lcd_rst),   32'd1);
        chk({tag, "_ready"},     32'(ready),     32'd0);
        chk({tag, "_fault"},     32'(fault),     32'd0);
        chk({tag, "_retry"},     32'(retry_cnt), 32'd0);
        chk({tag, "_loss"},      32'(loss_cnt),  32'd0);
    endtask

    task automatic wait_state(input logic [2:0] exp, input int budget, input string tag);
        int cnt;
        logic found;
        cnt   = 0;
        found = (state === exp);
        while (!found && cnt < budget) begin
            tick();
            cnt++;
            found = (state === exp);
        end
        chk({tag, "_reached"}, 32'(found), 32'd1);
    endtask

    task automatic pulse_restart();
        restart_req = 1'b1;
        tick();
        restart_req = 1'b0;
    endtask

    initial begin
        logic ready_seen;
        rst         = 1'b1;
        pll_lock    = 1'b0;
        restart_req = 1'b0;
        ticks(2);
        chk_reset_vals("t0_reset");

        // Test 1: first lock. Edge numbering starts at 1 after release.
        rst = 1'b0;
        ticks(3);
        chk("t1_e3_state", 32'(state), 32'd0);
        chk("t1_e3_pll_reset", 32'(pll_reset), 32'd1);
        tick();
        chk("t1_e4_state", 32'(state), 32'd1);
        chk("t1_e4_pll_reset", 32'(pll_reset), 32'd0);
        chk("t1_e4_lcd_rst", 32'(lcd_rst), 32'd1);
        ticks(5);
        pll_lock = 1'b1;
        ticks(2);
        chk("t1_e11_state", 32'(state), 32'd1);
        tick();
        chk("t1_e12_state", 32'(state), 32'd2);
        ticks(7);
        chk("t1_e19_state", 32'(state), 32'd2);
        chk("t1_e19_ready", 32'(ready), 32'd0);
        tick();
        chk("t1_e20_state", 32'(state), 32'd3);
        chk("t1_e20_ready", 32'(ready), 32'd1);
        chk("t1_e20_lcd_rst", 32'(lcd_rst), 32'd0);
        chk("t1_e20_pll_reset", 32'(pll_reset), 32'd0);
        chk("t1_e20_retry", 32'(retry_cnt), 32'd0);

        // Test 5a: restart from RUN leaves loss_cnt alone.
        pulse_restart();
        chk("t5a_state", 32'(state), 32'd0);
        chk("t5a_loss", 32'(loss_cnt), 32'd0);
        chk("t5a_ready", 32'(ready), 32'd0);
        chk("t5a_lcd_rst", 32'(lcd_rst), 32'd1);
        chk("t5a_pll_reset", 32'(pll_reset), 32'd1);
        ticks(12);
        chk("t5a_r12_state", 32'(state), 32'd2);
        tick();
        chk("t5a_r13_state", 32'(state), 32'd3);
        chk("t5a_r13_ready", 32'(ready), 32'd1);

        // Test 3: one-cycle lock glitch at stable count 5.
        pulse_restart();
        ticks(8);
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        tick();
        chk("t3_r10_state", 32'(state), 32'd2);
        tick();
        chk("t3_r11_state", 32'(state), 32'd1);
        tick();
        chk("t3_r12_state", 32'(state), 32'd2);
        ticks(7);
        chk("t3_r19_state", 32'(state), 32'd2);
        chk("t3_r19_ready", 32'(ready), 32'd0);
        tick();
        chk("t3_r20_state", 32'(state), 32'd3);
        chk("t3_r20_ready", 32'(ready), 32'd1);

        // Test 3b: lock toggling every 6 cycles never reaches RUN and times out.
        pulse_restart();
        ready_seen = 1'b0;
        for (int i = 1; i <= 36; i++) begin
            pll_lock = (((i - 1) / 6) % 2 == 0);
            tick();
            if (ready) ready_seen = 1'b1;
            if (i == 35) chk("t3b_r35_retry", 32'(retry_cnt), 32'd0);
        end
        chk("t3b_r36_state", 32'(state), 32'd0);
        chk("t3b_r36_retry", 32'(retry_cnt), 32'd1);
        chk("t3b_no_ready", 32'(ready_seen), 32'd0);
        pll_lock = 1'b1;
        wait_state(3'd3, 60, "t3b_recover");
        chk("t3b_recover_retry", 32'(retry_cnt), 32'd0);

        // Test 4: lock loss in RUN, two-cycle latency to pll_reset/lcd_rst.
        pll_lock = 1'b0;
        tick();
        chk("t4_n_lcd_rst", 32'(lcd_rst), 32'd0);
        tick();
        chk("t4_n1_state", 32'(state), 32'd3);
        tick();
        chk("t4_n2_lcd_rst", 32'(lcd_rst), 32'd1);
        chk("t4_n2_pll_reset", 32'(pll_reset), 32'd1);
        chk("t4_n2_state", 32'(state), 32'd0);
        chk("t4_n2_loss", 32'(loss_cnt), 32'd1);

        // Test 2: lock stays low, two 32-cycle timeouts end in FAULT.
        ticks(35);
        chk("t2_a35_state", 32'(state), 32'd1);
        chk("t2_a35_retry", 32'(retry_cnt), 32'd0);
        tick();
        chk("t2_a36_state", 32'(state), 32'd0);
        chk("t2_a36_retry", 32'(retry_cnt), 32'd1);
        chk("t2_a36_pll_reset", 32'(pll_reset), 32'd1);
        ticks(35);
        chk("t2_b35_state", 32'(state), 32'd1);
        chk("t2_b35_retry", 32'(retry_cnt), 32'd1);
        tick();
        chk("t2_b36_state", 32'(state), 32'd4);
        chk("t2_b36_retry", 32'(retry_cnt), 32'd2);
        chk("t2_b36_fault", 32'(fault), 32'd1);
        chk("t2_b36_pll_reset", 32'(pll_reset), 32'd1);
        chk("t2_b36_lcd_rst", 32'(lcd_rst), 32'd1);
        chk("t2_b36_ready", 32'(ready), 32'd0);
        ticks(50);
        chk("t2_hold_state", 32'(state), 32'd4);
        chk("t2_hold_fault", 32'(fault), 32'd1);
        chk("t2_hold_pll_reset", 32'(pll_reset), 32'd1);
        chk("t2_hold_lcd_rst", 32'(lcd_rst), 32'd1);
        chk("t2_hold_loss", 32'(loss_cnt), 32'd1);

        // Test 5b: restart out of FAULT.
        pll_lock = 1'b1;
        pulse_restart();
        chk("t5b_state", 32'(state), 32'd0);
        chk("t5b_fault", 32'(fault), 32'd0);
        chk("t5b_retry", 32'(retry_cnt), 32'd0);
        chk("t5b_loss", 32'(loss_cnt), 32'd1);
        ticks(12);
        chk("t5b_f12_state", 32'(state), 32'd2);
        tick();
        chk("t5b_f13_state", 32'(state), 32'd3);
        chk("t5b_f13_ready", 32'(ready), 32'd1);

        // Test 4b: lock loss and restart seen by the FSM on the same edge.
        pll_lock = 1'b0;
        ticks(2);
        restart_req = 1'b1;
        tick();
        restart_req = 1'b0;
        chk("t4b_state", 32'(state), 32'd0);
        chk("t4b_loss", 32'(loss_cnt), 32'd2);
        pll_lock = 1'b1;

        // restart_req is ignored while in STABLE.
        wait_state(3'd2, 20, "t4b_stable");
        pulse_restart();
        chk("ign_stable_state", 32'(state), 32'd2);
        wait_state(3'd3, 20, "ign_run");

        // Test 6a: async reset during STABLE.
        pulse_restart();
        wait_state(3'd2, 20, "t6a_stable");
        rst = 1'b1;
        #1;
        chk_reset_vals("t6a_rst");
        ticks(2);
        rst = 1'b0;

        // loss_cnt saturation: 255 losses, then one more must hold at 255.
        for (int i = 0; i < 256; i++) begin
            wait_state(3'd3, 40, "sat_run");
            pll_lock = 1'b0;
            tick();
            pll_lock = 1'b1;
            wait_state(3'd0, 10, "sat_drop");
            if (i == 254) chk("sat_at_255", 32'(loss_cnt), 32'd255);
        end
        chk("sat_hold", 32'(loss_cnt), 32'd255);

        // Test 6b: async reset during RUN with loss_cnt saturated.
        wait_state(3'd3, 40, "t6b_run");
        chk("t6b_pre_ready", 32'(ready), 32'd1);
        rst = 1'b1;
        #1;
        chk_reset_vals("t6b_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
